// File: rtl/line_follow_ctrl.sv
// Line-following steering controller: synchronised, debounced reflectance
// sensors feed a position classifier and a TRACK/NODE/LOST sequencing FSM.
module line_follow_ctrl #(
    parameter int NUM_SENSORS  = 3,
    parameter int FILT_CYCLES  = 4,
    parameter int LOST_TIMEOUT = 50000,
    parameter int CNT_W        = 8
) (
    input  logic                   clk_50,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensors,
    output logic [2:0]             turn,
    output logic                   node_valid,
    input  logic [2:0]             node_cmd,
    input  logic                   node_cmd_valid,
    output logic [CNT_W-1:0]       node_count,
    output logic                   lost
);

    // state       | meaning
    // S_IDLE      | disabled, turn=stop
    // S_TRACK     | follow line using classified position
    // S_NODE_WAIT | all sensors on line, node_valid high, awaiting planner
    // S_NODE_EXEC | drive latched planner command until node is cleared
    // S_LOST      | no line seen, sweep toward last direction, timeout running
    // S_HALT      | lost timeout expired, turn=halt until disabled
    // S_DONE      | planner issued stop, hold until disabled
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_NODE_WAIT,
        S_NODE_EXEC,
        S_LOST,
        S_HALT,
        S_DONE
    } state_t;

    localparam logic [2:0] T_STOP  = 3'b000;
    localparam logic [2:0] T_FWD   = 3'b001;
    localparam logic [2:0] T_LEFT  = 3'b010;
    localparam logic [2:0] T_RIGHT = 3'b011;
    localparam logic [2:0] T_HALT  = 3'b100;

    localparam int C  = NUM_SENSORS / 2;
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam int TW = $clog2(LOST_TIMEOUT);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOST_TIMEOUT - 1);
    localparam logic [NUM_SENSORS-1:0] CENTRE_ONLY = NUM_SENSORS'(1) << C;

    logic [NUM_SENSORS-1:0] sync_1, sync_2, filt;
    logic [FW-1:0]          stab_cnt [NUM_SENSORS];

    state_t        state;
    logic [2:0]    cmd_lat;
    logic          last_right;
    logic [TW-1:0] tmo_cnt;

    logic       cls_all, cls_none, centre_only;
    logic [2:0] cls_code;
    int         lc, rc;

    // A filtered bit only moves after FILT_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= '0;
            sync_2 <= '0;
            filt   <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) stab_cnt[i] <= '0;
        end else begin
            sync_1 <= sensors;
            sync_2 <= sync_1;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (sync_2[i] != filt[i]) begin
                    if (stab_cnt[i] == FILT_LAST) begin
                        filt[i]     <= sync_2[i];
                        stab_cnt[i] <= '0;
                    end else begin
                        stab_cnt[i] <= stab_cnt[i] + FW'(1);
                    end
                end else begin
                    stab_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        lc = 0;
        rc = 0;
        for (int i = 0; i < C; i++)                   lc = lc + int'(filt[i]);
        for (int i = C + 1; i < NUM_SENSORS; i++)     rc = rc + int'(filt[i]);
        cls_all     = &filt;
        cls_none    = ~|filt;
        centre_only = (filt == CENTRE_ONLY);
        if (lc > rc)      cls_code = T_LEFT;
        else if (rc > lc) cls_code = T_RIGHT;
        else              cls_code = T_FWD;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            turn       <= T_STOP;
            node_valid <= 1'b0;
            node_count <= '0;
            lost       <= 1'b0;
            cmd_lat    <= T_STOP;
            last_right <= 1'b0;
            tmo_cnt    <= '0;
        end else if (!enable) begin
            state      <= S_IDLE;
            turn       <= T_STOP;
            node_valid <= 1'b0;
            lost       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state <= S_TRACK;
                    turn  <= T_STOP;
                end
                S_TRACK: begin
                    if (cls_all) begin
                        state      <= S_NODE_WAIT;
                        turn       <= T_STOP;
                        node_valid <= 1'b1;
                    end else if (cls_none) begin
                        state   <= S_LOST;
                        tmo_cnt <= '0;
                        turn    <= last_right ? T_RIGHT : T_LEFT;
                        lost    <= 1'b1;
                    end else begin
                        turn <= cls_code;
                        if (cls_code == T_LEFT)       last_right <= 1'b0;
                        else if (cls_code == T_RIGHT) last_right <= 1'b1;
                    end
                end
                S_NODE_WAIT: begin
                    // node_valid is the registered flag, so an entry-cycle strobe is never taken
                    if (node_valid && node_cmd_valid) begin
                        node_count <= node_count + CNT_W'(1);
                        node_valid <= 1'b0;
                        if (node_cmd[2] || node_cmd == T_STOP) begin
                            cmd_lat <= T_STOP;
                            state   <= S_DONE;
                            turn    <= T_STOP;
                        end else begin
                            cmd_lat <= node_cmd;
                            state   <= S_NODE_EXEC;
                            turn    <= node_cmd;
                        end
                    end
                end
                S_NODE_EXEC: begin
                    if (!cls_all ||
                        ((cmd_lat == T_LEFT || cmd_lat == T_RIGHT) && centre_only)) begin
                        state <= S_TRACK;
                        if (!cls_none) turn <= cls_code;
                    end else begin
                        turn <= cmd_lat;
                    end
                end
                S_LOST: begin
                    if (!cls_none) begin
                        state   <= S_TRACK;
                        lost    <= 1'b0;
                        tmo_cnt <= '0;
                        turn    <= cls_code;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_HALT;
                        turn  <= T_HALT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_HALT: turn <= T_HALT;
                S_DONE: turn <= T_STOP;
                default: begin
                    state <= S_IDLE;
                    turn  <= T_STOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Scoreboard bench for line_follow_ctrl: a 3-sensor build with a short lost
// timeout and a 5-sensor build for wider classification.
module tb_line_follow_ctrl;

    logic       clk_50 = 1'b0;
    logic       rst_n;
    logic       enable, en5;
    logic [2:0] sensors;
    logic [4:0] sens5;
    logic [2:0] turn, turn5;
    logic       node_valid, node_valid5;
    logic [2:0] node_cmd;
    logic       node_cmd_valid;
    logic [7:0] node_count, node_count5;
    logic       lost, lost5;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #10 clk_50 = ~clk_50;

    line_follow_ctrl #(
        .NUM_SENSORS(3), .FILT_CYCLES(4), .LOST_TIMEOUT(20), .CNT_W(8)
    ) dut (
        .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .sensors(sensors),
        .turn(turn), .node_valid(node_valid), .node_cmd(node_cmd),
        .node_cmd_valid(node_cmd_valid), .node_count(node_count), .lost(lost)
    );

    line_follow_ctrl #(
        .NUM_SENSORS(5), .FILT_CYCLES(4), .LOST_TIMEOUT(20), .CNT_W(8)
    ) dut5 (
        .clk_50(clk_50), .rst_n(rst_n), .enable(en5), .sensors(sens5),
        .turn(turn5), .node_valid(node_valid5), .node_cmd(3'b000),
        .node_cmd_valid(1'b0), .node_count(node_count5), .lost(lost5)
    );

    localparam int O_TURN = 0, O_NV = 1, O_CNT = 2, O_LOST = 3, O_TURN5 = 4;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            O_TURN:  return {29'd0, turn};
            O_NV:    return {31'd0, node_valid};
            O_CNT:   return {24'd0, node_count};
            O_LOST:  return {31'd0, lost};
            default: return {29'd0, turn5};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
        sb_q.push_back('{tag, sel, exp});
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    // Vector bit 0 is the leftmost sensor, so "110" (left pair) is 3'b011.
    initial begin
        rst_n = 1'b0; enable = 1'b0; en5 = 1'b0;
        sensors = 3'b010; sens5 = 5'b00000;
        node_cmd = 3'b000; node_cmd_valid = 1'b0;
        #25;
        expect_out("rst_turn", O_TURN, 0);
        expect_out("rst_nv", O_NV, 0);
        expect_out("rst_cnt", O_CNT, 0);
        expect_out("rst_lost", O_LOST, 0);
        drain();
        @(negedge clk_50); rst_n = 1'b1;
        step(10);

        enable = 1'b1;
        step(1); expect_out("idle_to_track", O_TURN, 0); drain();
        step(1); expect_out("fwd", O_TURN, 1); expect_out("fwd_lost", O_LOST, 0); drain();

        sensors = 3'b011;
        step(6); expect_out("left_lat6", O_TURN, 1); drain();
        step(1); expect_out("left_lat7", O_TURN, 2); drain();

        sensors = 3'b110; step(2); sensors = 3'b011;
        step(10); expect_out("glitch_hold", O_TURN, 2); drain();

        sensors = 3'b111;
        step(6); expect_out("pre_node_nv", O_NV, 0); drain();
        node_cmd = 3'b011; node_cmd_valid = 1'b1;
        step(1); node_cmd_valid = 1'b0;
        expect_out("entry_strobe_cnt", O_CNT, 0);
        expect_out("node_nv", O_NV, 1);
        expect_out("node_turn", O_TURN, 0);
        drain();
        step(2); expect_out("node_wait_nv", O_NV, 1); drain();
        node_cmd_valid = 1'b1;
        step(1); node_cmd_valid = 1'b0;
        expect_out("accept_cnt", O_CNT, 1);
        expect_out("accept_turn", O_TURN, 3);
        expect_out("accept_nv", O_NV, 0);
        drain();
        step(3); expect_out("exec_turn", O_TURN, 3); drain();
        sensors = 3'b010;
        step(6); expect_out("exec_hold", O_TURN, 3); drain();
        step(1); expect_out("exec_exit", O_TURN, 1); drain();

        sensors = 3'b110;
        step(7); expect_out("right", O_TURN, 3); drain();

        sensors = 3'b000;
        step(7); expect_out("lost_turn", O_TURN, 3); expect_out("lost_flag", O_LOST, 1); drain();
        step(19); expect_out("lost_19", O_TURN, 3); drain();
        step(1); expect_out("halt_turn", O_TURN, 4); expect_out("halt_lost", O_LOST, 1); drain();
        step(5); expect_out("halt_hold", O_TURN, 4); drain();
        enable = 1'b0;
        step(1); expect_out("dis_turn", O_TURN, 0); expect_out("dis_lost", O_LOST, 0); drain();

        enable = 1'b1;
        step(2); expect_out("relost", O_LOST, 1); drain();
        step(10); sensors = 3'b010;
        step(6); expect_out("recov_pre", O_LOST, 1); drain();
        step(1); expect_out("recov_turn", O_TURN, 1); expect_out("recov_lost", O_LOST, 0); drain();

        sensors = 3'b111;
        step(7); expect_out("node2_nv", O_NV, 1); drain();
        node_cmd = 3'b101; node_cmd_valid = 1'b1;
        step(1); node_cmd_valid = 1'b0;
        expect_out("done_cnt", O_CNT, 2);
        expect_out("done_turn", O_TURN, 0);
        drain();
        sensors = 3'b010;
        step(10); expect_out("done_hold", O_TURN, 0); drain();
        enable = 1'b0; step(1); enable = 1'b1;
        step(2); expect_out("done_retrack", O_TURN, 1); drain();

        sens5 = 5'b01010;
        step(8); en5 = 1'b1;
        step(2); expect_out("n5_fwd", O_TURN5, 1); drain();
        sens5 = 5'b00011;
        step(6); expect_out("n5_left_pre", O_TURN5, 1); drain();
        step(1); expect_out("n5_left", O_TURN5, 2); drain();
        sens5 = 5'b11100;
        step(7); expect_out("n5_right", O_TURN5, 3); drain();

        sensors = 3'b111;
        step(7); expect_out("node3_nv", O_NV, 1); drain();
        #3 rst_n = 1'b0;
        #1;
        expect_out("arst_nv", O_NV, 0);
        expect_out("arst_turn", O_TURN, 0);
        expect_out("arst_cnt", O_CNT, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
